// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Shared CPU constants for the instruction-fetch stage: reset PC, the width of
// the fetch-to-decode bus, the fetch-stage state encodings and a helper that
// computes the sequential PC.
// -----------------------------------------------------------------------------
package if_stage_pkg;

    // fs_pc value held during reset; the first fetch address is PC_RESET + 4.
    localparam logic [31:0] PC_RESET        = 32'h1BFF_FFFC;
    localparam int          FS_TO_DS_BUS_WD = 64;

    // EMPTY: nothing fetched; RUN: instruction comes straight from SRAM;
    // HOLD: decode stalled, instruction parked in the inline buffer.
    typedef enum logic [1:0] {
        FS_EMPTY = 2'd0,
        FS_RUN   = 2'd1,
        FS_HOLD  = 2'd2
    } fs_state_e;

    // Sequential successor of a PC; wraps modulo 2^32.
    function automatic logic [31:0] seq_pc_of(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// -----------------------------------------------------------------------------
// if_stage_if
// Bundles the fetch stage's SRAM port, the decode handshake and the redirect
// inputs.
//   master : the fetch stage (drives SRAM request and fetch-to-decode bus)
//   slave  : environment (SRAM read data, decode ready, branch redirect)
// -----------------------------------------------------------------------------
interface if_stage_if;
    import if_stage_pkg::*;

    logic                       inst_sram_en;
    logic                       inst_sram_we;
    logic [31:0]                inst_sram_addr;
    logic [31:0]                inst_sram_wdata;
    logic [31:0]                inst_sram_rdata;
    logic                       ds_allow_in;
    logic                       br_taken;
    logic [31:0]                br_target;
    logic                       fs_to_ds_valid;
    logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;

    modport master (
        output inst_sram_en,
        output inst_sram_we,
        output inst_sram_addr,
        output inst_sram_wdata,
        input  inst_sram_rdata,
        input  ds_allow_in,
        input  br_taken,
        input  br_target,
        output fs_to_ds_valid,
        output fs_to_ds_bus
    );

    modport slave (
        input  inst_sram_en,
        input  inst_sram_we,
        input  inst_sram_addr,
        input  inst_sram_wdata,
        output inst_sram_rdata,
        output ds_allow_in,
        output br_taken,
        output br_target,
        input  fs_to_ds_valid,
        input  fs_to_ds_bus
    );

endinterface

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage. Issues one SRAM read per accepted fetch (address is
// nextpc), presents {fs_pc, fs_inst} to decode one cycle later, parks the
// returned word in an inline buffer while decode stalls, and applies branch
// redirects either immediately or, if the stage is stalled, on the next
// accepted fetch.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   bus_if : if_stage_if.master (SRAM port, decode handshake, redirect)
// -----------------------------------------------------------------------------
module if_stage
    import if_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    if_stage_if.master      bus_if
);

    fs_state_e   state_r;
    logic [31:0] fs_pc_r;
    logic [31:0] inst_buf_r;
    logic [31:0] br_buf_r;
    logic        br_pending_r;
    logic        br_cancel_r;

    logic        fs_valid_s;
    logic        inst_buf_valid_s;
    logic        fs_allow_in_s;
    logic [31:0] seq_pc_s;
    logic [31:0] nextpc_s;
    logic [31:0] fs_inst_s;

    // Next-PC selection, stage handshake and instruction source select.
    always_comb begin
        fs_valid_s       = (state_r != FS_EMPTY);
        inst_buf_valid_s = (state_r == FS_HOLD);
        fs_allow_in_s    = !fs_valid_s || bus_if.ds_allow_in;
        seq_pc_s         = seq_pc_of(fs_pc_r);
        // A live redirect beats a deferred one, which beats sequential flow.
        if (bus_if.br_taken) begin
            nextpc_s = bus_if.br_target;
        end else if (br_pending_r) begin
            nextpc_s = br_buf_r;
        end else begin
            nextpc_s = seq_pc_s;
        end
        if (inst_buf_valid_s) begin
            fs_inst_s = inst_buf_r;
        end else begin
            fs_inst_s = bus_if.inst_sram_rdata;
        end
    end

    assign bus_if.inst_sram_en    = !reset && fs_allow_in_s;
    assign bus_if.inst_sram_we    = 1'b0;
    assign bus_if.inst_sram_addr  = nextpc_s;
    assign bus_if.inst_sram_wdata = 32'h0000_0000;
    // An instruction that coincides with a redirect (or was cancelled by a
    // deferred one) belongs to the wrong path and is dropped.
    assign bus_if.fs_to_ds_valid  = !reset && fs_valid_s && !bus_if.br_taken && !br_cancel_r;
    assign bus_if.fs_to_ds_bus    = {fs_pc_r, fs_inst_s};

    // Fetch-stage FSM, PC register, instruction buffer and deferred redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= FS_EMPTY;
            fs_pc_r      <= PC_RESET;
            inst_buf_r   <= 32'h0000_0000;
            br_buf_r     <= 32'h0000_0000;
            br_pending_r <= 1'b0;
            br_cancel_r  <= 1'b0;
        end else if (fs_allow_in_s) begin
            // New fetch accepted: buffer and any deferred redirect are consumed.
            state_r      <= FS_RUN;
            fs_pc_r      <= nextpc_s;
            br_pending_r <= 1'b0;
            br_cancel_r  <= 1'b0;
        end else begin
            // Stalled: SRAM data is only valid for one cycle, so catch it now.
            case (state_r)
                FS_RUN: begin
                    inst_buf_r <= bus_if.inst_sram_rdata;
                    state_r    <= FS_HOLD;
                end
                FS_HOLD: begin
                    state_r    <= FS_HOLD;
                end
                default: begin
                    state_r    <= FS_EMPTY;
                end
            endcase
            // Redirect while stalled: remember it and kill the held instruction.
            if (bus_if.br_taken) begin
                br_pending_r <= 1'b1;
                br_buf_r     <= bus_if.br_target;
                br_cancel_r  <= 1'b1;
            end else begin
                br_pending_r <= br_pending_r;
                br_cancel_r  <= br_cancel_r;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage. A behavioural SRAM returns inst_of(addr)
// one cycle after an enabled read and random garbage otherwise. Each test
// drives cycles, checks combinational outputs inline, records every accepted
// decode handshake and compares it against the PCs it expects.
// -----------------------------------------------------------------------------
module tb_if_stage;
    import if_stage_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    logic [31:0] exp_pc[$];
    logic [31:0] obs_pc[$];
    logic [31:0] obs_inst[$];

    if_stage_if bus_if();

    if_stage dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    // SRAM model: data one cycle after an enabled read, garbage otherwise.
    always @(posedge clk) begin
        if (bus_if.inst_sram_en === 1'b1) bus_if.inst_sram_rdata <= inst_of(bus_if.inst_sram_addr);
        else                              bus_if.inst_sram_rdata <= $urandom;
    end

    // One cycle of stimulus; records any handshake accepted by decode.
    task automatic tick(input logic rst, input logic dsa, input logic bt, input logic [31:0] tgt);
        @(negedge clk);
        reset              = rst;
        bus_if.ds_allow_in = dsa;
        bus_if.br_taken    = bt;
        bus_if.br_target   = tgt;
        #2;
        if (bus_if.fs_to_ds_valid === 1'b1 && dsa) begin
            obs_pc.push_back(bus_if.fs_to_ds_bus[63:32]);
            obs_inst.push_back(bus_if.fs_to_ds_bus[31:0]);
        end
    endtask

    task automatic start_test();
        exp_pc.delete();
        obs_pc.delete();
        obs_inst.delete();
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        start_test();
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            n_cmp++;
            if (bus_if.inst_sram_en !== 1'b0 || bus_if.fs_to_ds_valid !== 1'b0) begin
                n_err++;
                $display("FAIL reset_en_valid[%0d]: got en=%b valid=%b want 0/0", k, bus_if.inst_sram_en, bus_if.fs_to_ds_valid);
            end
        end
        n_cmp++;
        if (bus_if.inst_sram_we !== 1'b0 || bus_if.inst_sram_wdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_we_wdata: got %b/%h want 0/00000000", bus_if.inst_sram_we, bus_if.inst_sram_wdata);
        end
        n_cmp++;
        if (obs_pc.size() != 0) begin
            n_err++;
            $display("FAIL reset_no_output: got %0d handshakes want 0", obs_pc.size());
        end
    endtask

    task automatic test_sequential();
        start_test();
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 1'b1, 1'b0, 32'h0);
            n_cmp++;
            if (bus_if.inst_sram_en !== 1'b1 || bus_if.inst_sram_addr !== 32'h1C00_0000 + 32'd4 * k) begin
                n_err++;
                $display("FAIL seq_addr[%0d]: got en=%b addr=%h want 1/%h", k, bus_if.inst_sram_en, bus_if.inst_sram_addr, 32'h1C00_0000 + 32'd4 * k);
            end
        end
        for (int k = 0; k < 5; k++) exp_pc.push_back(32'h1C00_0000 + 32'd4 * k);
        n_cmp++;
        if (obs_pc.size() != exp_pc.size()) begin
            n_err++; $display("FAIL seq_count: got %0d want %0d", obs_pc.size(), exp_pc.size());
        end
        foreach (exp_pc[i]) if (i < obs_pc.size()) begin
            n_cmp++;
            if (obs_pc[i] !== exp_pc[i] || obs_inst[i] !== inst_of(exp_pc[i])) begin
                n_err++; $display("FAIL seq_pair[%0d]: got %h/%h want %h/%h", i, obs_pc[i], obs_inst[i], exp_pc[i], inst_of(exp_pc[i]));
            end
        end
    endtask

    task automatic test_stall();
        start_test();
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0);
            n_cmp++;
            if (bus_if.inst_sram_en !== 1'b0 || bus_if.fs_to_ds_valid !== 1'b1 ||
                bus_if.fs_to_ds_bus !== {32'h1C00_0004, inst_of(32'h1C00_0004)}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got en=%b valid=%b bus=%h want 0/1/%h", k, bus_if.inst_sram_en,
                         bus_if.fs_to_ds_valid, bus_if.fs_to_ds_bus, {32'h1C00_0004, inst_of(32'h1C00_0004)});
            end
        end
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        n_cmp++;
        if (bus_if.inst_sram_en !== 1'b1 || bus_if.inst_sram_addr !== 32'h1C00_0008) begin
            n_err++; $display("FAIL stall_release_addr: got %b/%h want 1/1c000008", bus_if.inst_sram_en, bus_if.inst_sram_addr);
        end
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        exp_pc.push_back(32'h1C00_0000); exp_pc.push_back(32'h1C00_0004); exp_pc.push_back(32'h1C00_0008);
        n_cmp++;
        if (obs_pc.size() != exp_pc.size()) begin
            n_err++; $display("FAIL stall_count: got %0d want %0d", obs_pc.size(), exp_pc.size());
        end
        foreach (exp_pc[i]) if (i < obs_pc.size()) begin
            n_cmp++;
            if (obs_pc[i] !== exp_pc[i] || obs_inst[i] !== inst_of(exp_pc[i])) begin
                n_err++; $display("FAIL stall_pair[%0d]: got %h/%h want %h/%h", i, obs_pc[i], obs_inst[i], exp_pc[i], inst_of(exp_pc[i]));
            end
        end
    endtask

    task automatic test_branch();
        start_test();
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 32'h1C00_0100);
        n_cmp++;
        if (bus_if.fs_to_ds_valid !== 1'b0 || bus_if.inst_sram_addr !== 32'h1C00_0100) begin
            n_err++; $display("FAIL branch_redirect: got valid=%b addr=%h want 0/1c000100", bus_if.fs_to_ds_valid, bus_if.inst_sram_addr);
        end
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        n_cmp++;
        if (bus_if.inst_sram_addr !== 32'h1C00_0104) begin
            n_err++; $display("FAIL branch_next_addr: got %h want 1c000104", bus_if.inst_sram_addr);
        end
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        exp_pc.push_back(32'h1C00_0000); exp_pc.push_back(32'h1C00_0100); exp_pc.push_back(32'h1C00_0104);
        n_cmp++;
        if (obs_pc.size() != exp_pc.size()) begin
            n_err++; $display("FAIL branch_count: got %0d want %0d", obs_pc.size(), exp_pc.size());
        end
        foreach (exp_pc[i]) if (i < obs_pc.size()) begin
            n_cmp++;
            if (obs_pc[i] !== exp_pc[i] || obs_inst[i] !== inst_of(exp_pc[i])) begin
                n_err++; $display("FAIL branch_pair[%0d]: got %h/%h want %h/%h", i, obs_pc[i], obs_inst[i], exp_pc[i], inst_of(exp_pc[i]));
            end
        end
    endtask

    task automatic test_branch_stall();
        start_test();
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 32'h1C00_0200);
        n_cmp++;
        if (bus_if.fs_to_ds_valid !== 1'b0 || bus_if.inst_sram_en !== 1'b0) begin
            n_err++; $display("FAIL brstall_pulse: got valid=%b en=%b want 0/0", bus_if.fs_to_ds_valid, bus_if.inst_sram_en);
        end
        for (int k = 0; k < 2; k++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0);
            n_cmp++;
            if (bus_if.fs_to_ds_valid !== 1'b0) begin
                n_err++; $display("FAIL brstall_cancel[%0d]: got valid=%b want 0", k, bus_if.fs_to_ds_valid);
            end
        end
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        n_cmp++;
        if (bus_if.fs_to_ds_valid !== 1'b0 || bus_if.inst_sram_en !== 1'b1 || bus_if.inst_sram_addr !== 32'h1C00_0200) begin
            n_err++; $display("FAIL brstall_release: got valid=%b en=%b addr=%h want 0/1/1c000200",
                              bus_if.fs_to_ds_valid, bus_if.inst_sram_en, bus_if.inst_sram_addr);
        end
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        exp_pc.push_back(32'h1C00_0000); exp_pc.push_back(32'h1C00_0200); exp_pc.push_back(32'h1C00_0204);
        n_cmp++;
        if (obs_pc.size() != exp_pc.size()) begin
            n_err++; $display("FAIL brstall_count: got %0d want %0d", obs_pc.size(), exp_pc.size());
        end
        foreach (exp_pc[i]) if (i < obs_pc.size()) begin
            n_cmp++;
            if (obs_pc[i] !== exp_pc[i] || obs_inst[i] !== inst_of(exp_pc[i])) begin
                n_err++; $display("FAIL brstall_pair[%0d]: got %h/%h want %h/%h", i, obs_pc[i], obs_inst[i], exp_pc[i], inst_of(exp_pc[i]));
            end
        end
    endtask

    task automatic test_wrap();
        start_test();
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        n_cmp++;
        if (bus_if.inst_sram_addr !== 32'h0000_0000) begin
            n_err++; $display("FAIL wrap_addr: got %h want 00000000", bus_if.inst_sram_addr);
        end
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        exp_pc.push_back(32'hFFFF_FFFC); exp_pc.push_back(32'h0000_0000);
        n_cmp++;
        if (obs_pc.size() != exp_pc.size()) begin
            n_err++; $display("FAIL wrap_count: got %0d want %0d", obs_pc.size(), exp_pc.size());
        end
        foreach (exp_pc[i]) if (i < obs_pc.size()) begin
            n_cmp++;
            if (obs_pc[i] !== exp_pc[i] || obs_inst[i] !== inst_of(exp_pc[i])) begin
                n_err++; $display("FAIL wrap_pair[%0d]: got %h/%h want %h/%h", i, obs_pc[i], obs_inst[i], exp_pc[i], inst_of(exp_pc[i]));
            end
        end
    endtask

    task automatic test_reset_mid();
        start_test();
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 32'h1C00_0300);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (bus_if.inst_sram_en !== 1'b0 || bus_if.fs_to_ds_valid !== 1'b0) begin
            n_err++; $display("FAIL midrst_outputs: got en=%b valid=%b want 0/0", bus_if.inst_sram_en, bus_if.fs_to_ds_valid);
        end
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        n_cmp++;
        if (bus_if.inst_sram_addr !== 32'h1C00_0000 || bus_if.fs_to_ds_valid !== 1'b0) begin
            n_err++; $display("FAIL midrst_first_fetch: got addr=%h valid=%b want 1c000000/0", bus_if.inst_sram_addr, bus_if.fs_to_ds_valid);
        end
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        exp_pc.push_back(32'h1C00_0000); exp_pc.push_back(32'h1C00_0000); exp_pc.push_back(32'h1C00_0004);
        n_cmp++;
        if (obs_pc.size() != exp_pc.size()) begin
            n_err++; $display("FAIL midrst_count: got %0d want %0d", obs_pc.size(), exp_pc.size());
        end
        foreach (exp_pc[i]) if (i < obs_pc.size()) begin
            n_cmp++;
            if (obs_pc[i] !== exp_pc[i] || obs_inst[i] !== inst_of(exp_pc[i])) begin
                n_err++; $display("FAIL midrst_pair[%0d]: got %h/%h want %h/%h", i, obs_pc[i], obs_inst[i], exp_pc[i], inst_of(exp_pc[i]));
            end
        end
    endtask

    initial begin
        n_cmp              = 0;
        n_err              = 0;
        reset              = 1'b1;
        bus_if.ds_allow_in = 1'b1;
        bus_if.br_taken    = 1'b0;
        bus_if.br_target   = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_branch_stall();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port inst_sram_en, output, 1 bit: SRAM read enable.
REQ-004 SHALL have port inst_sram_we, output, 1 bit: SRAM write enable; tied 0.
REQ-005 SHALL have port inst_sram_addr, output, 32 bits: fetch address (equal to nextpc).
REQ-006 SHALL have port inst_sram_wdata, output, 32 bits: write data; tied 0.
REQ-007 SHALL have port inst_sram_rdata, input, 32 bits: read data, valid one cycle after en.
REQ-008 SHALL have port ds_allow_in, input, 1 bit: decode accepts this cycle.
REQ-009 SHALL have port br_taken, input, 1 bit: redirect request, single-cycle pulse from decode.
REQ-010 SHALL have port br_target, input, 32 bits: redirect PC, qualified by br_taken.
REQ-011 SHALL have port fs_to_ds_valid, output, 1 bit: fetched instruction valid to decode.
REQ-012 SHALL have port fs_to_ds_bus, output, 64 bits: {fs_pc[31:0], fs_inst[31:0]}.

Function
REQ-013 SHALL define seq_pc = fs_pc + 4, modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
REQ-014 SHALL select nextpc with priority: br_taken ? br_target : br_pending ? br_buf : seq_pc.
REQ-015 SHALL define fs_allow_in = !fs_valid || ds_allow_in (fs_ready_go is constant 1).
REQ-016 SHALL drive inst_sram_en = !reset && fs_allow_in.
REQ-017 SHALL, on each edge where fs_allow_in = 1: fs_pc <= nextpc, fs_valid <= 1, and clear br_pending.
REQ-018 SHALL drive fs_inst = inst_buf_valid ? inst_buf : inst_sram_rdata.
REQ-019 SHALL drive fs_to_ds_valid = fs_valid && !br_taken && !br_cancel; an instruction that coincides with a redirect is discarded.
REQ-020 SHALL implement three states: EMPTY (!fs_valid); RUN (fs_valid, !inst_buf_valid); HOLD (fs_valid, inst_buf_valid).
REQ-021 SHALL transition RUN->HOLD when !ds_allow_in: inst_buf <= inst_sram_rdata, inst_buf_valid <= 1.
REQ-022 SHALL transition HOLD->RUN when ds_allow_in: inst_buf_valid <= 0.
REQ-023 SHALL transition EMPTY->RUN on the first edge after reset deasserts.
REQ-024 SHALL, on br_taken while fs_allow_in = 0: br_pending <= 1, br_buf <= br_target, br_cancel <= 1 (the held instruction is cancelled); the redirect is applied on the next edge where fs_allow_in = 1.
REQ-025 SHALL give a later br_taken priority over, and overwrite, an existing br_pending/br_buf.
REQ-026 SHALL clear br_cancel and inst_buf_valid whenever a new fetch is accepted (fs_allow_in = 1).
REQ-027 SHALL complete a fetch in 1 cycle: address issued at edge N, instruction presented to decode after edge N+1.
REQ-028 SHALL never issue two outstanding SRAM reads; inst_sram_addr is not sampled while inst_sram_en = 0.

Reset
REQ-029 SHALL, while reset = 1, set fs_pc = 0x1BFFFFFC (so the first fetch address is 0x1C000000), and clear fs_valid, inst_buf_valid, br_pending and br_cancel.
REQ-030 SHALL hold fs_to_ds_valid = 0 and inst_sram_en = 0 during reset.
REQ-031 SHALL abandon any in-flight fetch, pending redirect or buffered instruction when reset is asserted mid-operation.

Structure
REQ-032 SHALL take PC_RESET = 32'h1BFFFFFC, FS_TO_DS_BUS_WD = 64 and the state encodings from the shared CPU package.
REQ-033 SHALL be implemented as a single module with no sub-modules; the instruction buffer is inline.
REQ-034 SHALL be purely registered state plus the combinational logic of REQ-013 to REQ-019 (no latches).

Verification
REQ-035 Release reset with ds_allow_in = 1 -> inst_sram_addr = 0x1C000000, 0x1C000004, 0x1C000008 on consecutive cycles; the bus carries matching PC/inst pairs.
REQ-036 Hold ds_allow_in = 0 for 3 cycles while SRAM rdata changes -> fs_inst stays at the first captured word and fs_pc is unchanged; on release the next address is fs_pc + 4.
REQ-037 Pulse br_taken with br_target = 0x1C000100 while ds_allow_in = 1 -> fs_to_ds_valid = 0 that cycle; the next fetched PC is 0x1C000100.
REQ-038 Pulse br_taken with br_target = 0x1C000200 while ds_allow_in = 0, release 2 cycles later -> the held instruction is never presented; the next PC is 0x1C000200.
REQ-039 Set fs_pc = 0xFFFFFFFC with no branch -> nextpc = 0x00000000.
REQ-040 Assert reset for 1 cycle in the middle of a HOLD with a pending branch -> the first fetch after reset is 0x1C000000 and no stale instruction appears.
